// File: rtl/ysyx_23060184_mem_arbiter.sv
// rtl/ysyx_23060184_mem_arbiter.sv - IFU/LSU read arbiter with AR/R steering (optional ARB_RR_EN round-robin)
module ysyx_23060184_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int IDLE_GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ifu_req,
  input  logic                  lsu_req,
  input  logic                  ifu_done,
  input  logic                  lsu_done,
  output logic                  ifu_grant,
  output logic                  lsu_grant,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr,
  input  logic                  ifu_arvalid,
  input  logic                  lsu_arvalid,
  input  logic                  ifu_rready,
  input  logic                  lsu_rready,
  output logic                  ifu_arready,
  output logic                  lsu_arready,
  output logic                  ifu_rvalid,
  output logic                  lsu_rvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  output logic                  rready,
  input  logic                  arready,
  input  logic                  rvalid,
  output logic                  proto_err
);

  localparam int GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(IDLE_GAP);

  typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic          ar_pend;
  logic          pick_lsu;
  logic          ar_hs;
  logic          r_hs;

`ifdef ARB_RR_EN
  // last_lsu=1 means the LSU received the most recent grant
  logic last_lsu;
  assign pick_lsu = lsu_req && (!ifu_req || !last_lsu);
`else
  assign pick_lsu = lsu_req;
`endif

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // Steer the shared AR/R handshake to whichever master holds the grant
  always_comb begin
    araddr      = '0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    if (ifu_grant) begin
      araddr      = ifu_araddr;
      arvalid     = ifu_arvalid;
      rready      = ifu_rready;
      ifu_arready = arready;
      ifu_rvalid  = rvalid;
    end else if (lsu_grant) begin
      araddr      = lsu_araddr;
      arvalid     = lsu_arvalid;
      rready      = lsu_rready;
      lsu_arready = arready;
      lsu_rvalid  = rvalid;
    end
  end

  // Grant FSM: only done releases the bus; stray or early done is latched as an error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ifu_grant <= 1'b0;
      lsu_grant <= 1'b0;
      gap_cnt   <= '0;
      ar_pend   <= 1'b0;
      proto_err <= 1'b0;
`ifdef ARB_RR_EN
      last_lsu  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ifu_done || lsu_done) proto_err <= 1'b1;
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GW'(1);
          end else if (pick_lsu) begin
            state     <= GNT_LSU;
            lsu_grant <= 1'b1;
`ifdef ARB_RR_EN
            last_lsu  <= 1'b1;
`endif
          end else if (ifu_req) begin
            state     <= GNT_IFU;
            ifu_grant <= 1'b1;
`ifdef ARB_RR_EN
            last_lsu  <= 1'b0;
`endif
          end
        end
        GNT_IFU: begin
          if (lsu_done) proto_err <= 1'b1;
          if (ifu_done) begin
            state     <= IDLE;
            ifu_grant <= 1'b0;
            gap_cnt   <= GAP_INIT;
            ar_pend   <= 1'b0;
            if (ar_pend) proto_err <= 1'b1;
          end else if (ar_hs) begin
            ar_pend <= 1'b1;
          end else if (r_hs) begin
            ar_pend <= 1'b0;
          end
        end
        GNT_LSU: begin
          if (ifu_done) proto_err <= 1'b1;
          if (lsu_done) begin
            state     <= IDLE;
            lsu_grant <= 1'b0;
            gap_cnt   <= GAP_INIT;
            ar_pend   <= 1'b0;
            if (ar_pend) proto_err <= 1'b1;
          end else if (ar_hs) begin
            ar_pend <= 1'b1;
          end else if (r_hs) begin
            ar_pend <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          ifu_grant <= 1'b0;
          lsu_grant <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_mem_arbiter.sv
// tb/tb_ysyx_23060184_mem_arbiter.sv - directed vector bench for ysyx_23060184_mem_arbiter
module tb_ysyx_23060184_mem_arbiter;

  localparam int AW = 32;
  localparam logic [AW-1:0] IFU_A = 32'h3000_0000;
  localparam logic [AW-1:0] LSU_A = 32'h8000_0100;

  logic clk = 1'b0;
  logic rstn;
  logic ifu_req, lsu_req, ifu_done, lsu_done;
  logic ifu_grant, lsu_grant;
  logic [AW-1:0] ifu_araddr, lsu_araddr, araddr;
  logic ifu_arvalid, lsu_arvalid, ifu_rready, lsu_rready;
  logic ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid;
  logic arvalid, rready, arready, rvalid, proto_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  ysyx_23060184_mem_arbiter #(.ADDR_WIDTH(AW), .IDLE_GAP(1)) dut (
    .clk(clk), .rstn(rstn),
    .ifu_req(ifu_req), .lsu_req(lsu_req), .ifu_done(ifu_done), .lsu_done(lsu_done),
    .ifu_grant(ifu_grant), .lsu_grant(lsu_grant),
    .ifu_araddr(ifu_araddr), .lsu_araddr(lsu_araddr),
    .ifu_arvalid(ifu_arvalid), .lsu_arvalid(lsu_arvalid),
    .ifu_rready(ifu_rready), .lsu_rready(lsu_rready),
    .ifu_arready(ifu_arready), .lsu_arready(lsu_arready),
    .ifu_rvalid(ifu_rvalid), .lsu_rvalid(lsu_rvalid),
    .araddr(araddr), .arvalid(arvalid), .rready(rready),
    .arready(arready), .rvalid(rvalid), .proto_err(proto_err)
  );

  // in = {ifu_req,lsu_req,ifu_done,lsu_done,ifu_arvalid,lsu_arvalid,ifu_rready,lsu_rready,arready,rvalid}
  // ex = {ifu_grant,lsu_grant,arvalid,rready,ifu_arready,lsu_arready,ifu_rvalid,lsu_rvalid}
  // sel: 0 araddr=0, 1 IFU address, 2 LSU address
  typedef struct packed {
    logic [9:0] in;
    logic [7:0] ex;
    logic [1:0] sel;
    logic       pe;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {ifu_req, lsu_req, ifu_done, lsu_done, ifu_arvalid, lsu_arvalid,
     ifu_rready, lsu_rready, arready, rvalid} = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rstn = 1'b0;
    #1;
    chk("reset_proto_err", {31'd0, proto_err}, 32'd0);
    chk("reset_grants", {30'd0, ifu_grant, lsu_grant}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Returns at negedge+1 of the first cycle a grant is visible; who: 1 IFU, 2 LSU, 0 timeout
  task automatic wait_grant(output int who);
    who = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (ifu_grant) begin who = 1; break; end
      if (lsu_grant) begin who = 2; break; end
    end
    if (who == 0) begin
      fails++;
      checks++;
      $display("FAIL wait_grant: got timeout expected a grant");
    end
  endtask

  initial begin
    int who;
    int exp_who [4];
    logic [AW-1:0] exp_addr;

    vecs[0]  = '{10'b0000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[1]  = '{10'b1000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[2]  = '{10'b1000100010, 8'b10101000, 2'd1, 1'b0};
    vecs[3]  = '{10'b1000001001, 8'b10010010, 2'd1, 1'b0};
    vecs[4]  = '{10'b0000000000, 8'b10000000, 2'd1, 1'b0};
    vecs[5]  = '{10'b0010000000, 8'b10000000, 2'd1, 1'b0};
    vecs[6]  = '{10'b0000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[7]  = '{10'b0000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[8]  = '{10'b1100000000, 8'b00000000, 2'd0, 1'b0};
    vecs[9]  = '{10'b1100111010, 8'b01100100, 2'd2, 1'b0};
    vecs[10] = '{10'b1100100101, 8'b01010001, 2'd2, 1'b0};
    vecs[11] = '{10'b1001000000, 8'b01000000, 2'd2, 1'b0};
    vecs[12] = '{10'b1000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[13] = '{10'b1000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[14] = '{10'b1000000000, 8'b10000000, 2'd1, 1'b0};
    vecs[15] = '{10'b0010000000, 8'b10000000, 2'd1, 1'b0};
    vecs[16] = '{10'b0000000000, 8'b00000000, 2'd0, 1'b0};
    vecs[17] = '{10'b0000000000, 8'b00000000, 2'd0, 1'b0};

    ifu_araddr = IFU_A;
    lsu_araddr = LSU_A;
    clear_inputs();
    rstn = 1'b0;
    #1;
    chk("por_outputs", {24'd0, ifu_grant, lsu_grant, arvalid, rready,
                        ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}, 32'd0);
    chk("por_araddr", araddr, 32'd0);
    chk("por_proto_err", {31'd0, proto_err}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Table: drive at negedge, check combinational view of current state, then the posedge advances it
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      {ifu_req, lsu_req, ifu_done, lsu_done, ifu_arvalid, lsu_arvalid,
       ifu_rready, lsu_rready, arready, rvalid} = vecs[i].in;
      #1;
      chk($sformatf("vec%0d_outs", i),
          {24'd0, ifu_grant, lsu_grant, arvalid, rready,
           ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid},
          {24'd0, vecs[i].ex});
      exp_addr = (vecs[i].sel == 2'd1) ? IFU_A : (vecs[i].sel == 2'd2) ? LSU_A : '0;
      chk($sformatf("vec%0d_araddr", i), araddr, exp_addr);
      chk($sformatf("vec%0d_proto_err", i), {31'd0, proto_err}, {31'd0, vecs[i].pe});
    end

    // Back-to-back rounds with both masters requesting
`ifdef ARB_RR_EN
    exp_who = '{2, 1, 2, 1};
`else
    exp_who = '{2, 2, 2, 2};
`endif
    @(negedge clk);
    clear_inputs();
    ifu_req = 1'b1;
    lsu_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_grant(who);
      chk($sformatf("round%0d_owner", r), who, exp_who[r]);
      chk($sformatf("round%0d_onehot", r), {31'd0, ifu_grant & lsu_grant}, 32'd0);
      if (who == 1) ifu_done = 1'b1;
      if (who == 2) lsu_done = 1'b1;
      @(negedge clk);
      ifu_done = 1'b0;
      lsu_done = 1'b0;
      #1;
      chk($sformatf("round%0d_release", r), {30'd0, ifu_grant, lsu_grant}, 32'd0);
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("rounds_no_err", {31'd0, proto_err}, 32'd0);

    // Done while an AR is outstanding: release happens, error sticks until reset
    lsu_req = 1'b1;
    wait_grant(who);
    chk("pend_owner", who, 32'd2);
    lsu_req = 1'b0;
    lsu_arvalid = 1'b1;
    arready = 1'b1;
    @(negedge clk);
    lsu_arvalid = 1'b0;
    arready = 1'b0;
    lsu_done = 1'b1;
    @(negedge clk);
    lsu_done = 1'b0;
    #1;
    chk("pend_released", {31'd0, lsu_grant}, 32'd0);
    chk("pend_proto_err", {31'd0, proto_err}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("pend_proto_err_sticky", {31'd0, proto_err}, 32'd1);
    do_reset();

    // Done in IDLE is an error
    @(negedge clk);
    ifu_done = 1'b1;
    @(negedge clk);
    ifu_done = 1'b0;
    #1;
    chk("idle_done_err", {31'd0, proto_err}, 32'd1);
    do_reset();

    // Done from the non-granted master is an error and does not release
    ifu_req = 1'b1;
    wait_grant(who);
    chk("stray_owner", who, 32'd1);
    lsu_done = 1'b1;
    @(negedge clk);
    lsu_done = 1'b0;
    #1;
    chk("stray_err", {31'd0, proto_err}, 32'd1);
    chk("stray_hold", {30'd0, ifu_grant, lsu_grant}, 32'd2);
    ifu_done = 1'b1;
    @(negedge clk);
    ifu_done = 1'b0;
    do_reset();

    // Asynchronous reset mid-grant with arvalid high
    ifu_req = 1'b1;
    wait_grant(who);
    chk("async_owner", who, 32'd1);
    ifu_arvalid = 1'b1;
    #1;
    chk("async_pre_arvalid", {31'd0, arvalid}, 32'd1);
    chk("async_pre_araddr", araddr, IFU_A);
    #1;
    rstn = 1'b0;
    #1;
    chk("async_grant", {30'd0, ifu_grant, lsu_grant}, 32'd0);
    chk("async_arvalid", {31'd0, arvalid}, 32'd0);
    chk("async_araddr", araddr, 32'd0);
    @(negedge clk);
    clear_inputs();
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
